// File: rtl/pcie_str_pkg.sv
// Shared constants and width helper for the PCIe stream buffers.
package pcie_str_pkg;

  localparam int STR_DATA_W    = 64;
  localparam int STR_BUF_DEPTH = 16;

  // ceil(log2(n)); returns 0 for n <= 1
  function automatic int clog2_w(input int unsigned n);
    int unsigned v;
    int          r;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/str_fifo_mem.sv
// Dual-port storage array for the stream buffer: clocked write port, asynchronous read port.
module str_fifo_mem
  import pcie_str_pkg::*;
#(
  parameter int DATA_W = STR_DATA_W,
  parameter int DEPTH  = STR_BUF_DEPTH,
  parameter int ADDR_W = clog2_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pcie_str_out_buf.sv
// Per-stream FWFT output buffer between user logic and the PCIe stream DMA engine.
// Optional word counter on the read side is enabled with `define STR_BUF_STATS_EN.
module pcie_str_out_buf
  import pcie_str_pkg::*;
#(
  parameter int DATA_W   = STR_DATA_W,
  parameter int DEPTH    = STR_BUF_DEPTH,
  parameter int AFULL_TH = 12
) (
  input  logic                      i_user_clk,
  input  logic                      i_rst_n,
  input  logic                      i_data_valid,
  input  logic [DATA_W-1:0]         i_data,
  output logic                      o_ack,
  output logic                      o_data_valid,
  output logic [DATA_W-1:0]         o_data,
  input  logic                      i_ack,
  output logic [clog2_w(DEPTH):0]   o_count,
  output logic                      o_afull,
  output logic                      o_overflow,
`ifdef STR_BUF_STATS_EN
  output logic [31:0]               o_word_cnt,
  input  logic                      i_clr_stats,
`endif
  input  logic                      i_clr_overflow
);

  localparam int ADDR_W = clog2_w(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] mem_rd_data, head_nxt;
  logic              full, wr_en, rd_en, drop;

  assign full  = (o_count == CNT_W'(DEPTH));
  assign o_ack = !full;
  assign wr_en = i_data_valid && !full;
  assign drop  = i_data_valid && full;
  assign rd_en = o_data_valid && i_ack;

  // Read port looks one entry ahead so the head register can refill on a read
  str_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (i_user_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (i_data),
    .rd_addr (rd_ptr + ADDR_W'(1)),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    count_nxt = o_count;
    if (wr_en && !rd_en) count_nxt = o_count + CNT_W'(1);
    else if (rd_en && !wr_en) count_nxt = o_count - CNT_W'(1);
  end

  // Head bypasses the array when the incoming word becomes the only entry
  always_comb begin
    head_nxt = o_data;
    if (rd_en && o_count > CNT_W'(1)) head_nxt = mem_rd_data;
    else if (wr_en && (o_count == '0 || rd_en)) head_nxt = i_data;
  end

  always_ff @(posedge i_user_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_count      <= '0;
      o_data_valid <= 1'b0;
      o_afull      <= 1'b0;
      o_data       <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      o_count      <= count_nxt;
      o_data_valid <= (count_nxt != '0);
      o_afull      <= (count_nxt >= CNT_W'(AFULL_TH));
      o_data       <= head_nxt;
      if (drop) o_overflow <= 1'b1;
      else if (i_clr_overflow) o_overflow <= 1'b0;
    end
  end

`ifdef STR_BUF_STATS_EN
  always_ff @(posedge i_user_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_word_cnt <= '0;
    else if (i_clr_stats) o_word_cnt <= rd_en ? 32'd1 : 32'd0;
    else if (rd_en) o_word_cnt <= o_word_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pcie_str_out_buf.sv
// Directed self-checking bench for pcie_str_out_buf (default 64-bit, 16-deep configuration).
module tb_pcie_str_out_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_valid = 1'b0;
  logic [63:0] data_in = '0;
  logic        ack_out;
  logic        head_valid;
  logic [63:0] head_data;
  logic        ack_in = 1'b0;
  logic [4:0]  count;
  logic        afull;
  logic        overflow;
  logic        clr_overflow = 1'b0;
`ifdef STR_BUF_STATS_EN
  logic [31:0] word_cnt;
  logic        clr_stats = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int mcnt = 0;
  int reads = 0;
  bit mdrop = 0;
  bit rd, wr;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  pcie_str_out_buf #(
    .DATA_W   (64),
    .DEPTH    (16),
    .AFULL_TH (12)
  ) dut (
    .i_user_clk     (clk),
    .i_rst_n        (rst_n),
    .i_data_valid   (data_valid),
    .i_data         (data_in),
    .o_ack          (ack_out),
    .o_data_valid   (head_valid),
    .o_data         (head_data),
    .i_ack          (ack_in),
    .o_count        (count),
    .o_afull        (afull),
    .o_overflow     (overflow),
`ifdef STR_BUF_STATS_EN
    .o_word_cnt     (word_cnt),
    .i_clr_stats    (clr_stats),
`endif
    .i_clr_overflow (clr_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #12;
    check("rst_count", 64'(count), 64'(0));
    check("rst_valid", 64'(head_valid), 64'(0));
    check("rst_afull", 64'(afull), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_data", head_data, 64'(0));
    #5 rst_n = 1'b1;
    check("rst_ack", 64'(ack_out), 64'(1));
    step();

    // single word with 1-cycle FWFT latency
    ack_in = 1'b1; data_valid = 1'b1; data_in = 64'h0123456789ABCDEF;
    step();
    data_valid = 1'b0;
    check("single_valid", 64'(head_valid), 64'(1));
    check("single_data", head_data, 64'h0123456789ABCDEF);
    check("single_count", 64'(count), 64'(1));
    check("single_ack", 64'(ack_out), 64'(1));
    step();
    reads++;
    check("single_cnt0", 64'(count), 64'(0));
    check("single_valid0", 64'(head_valid), 64'(0));
    check("single_ack1", 64'(ack_out), 64'(1));

    // fill with no reads
    ack_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      data_valid = 1'b1; data_in = 64'(i);
      step();
      check("fill_count", 64'(count), 64'(i + 1));
      check("fill_afull", 64'(afull), 64'(i + 1 >= 12));
      check("fill_ack", 64'(ack_out), 64'(i + 1 < 16));
      check("fill_head", head_data, 64'(0));
    end

    // overflow: drop, set-beats-clear, clear
    data_in = 64'hDEAD;
    step();
    check("ovf_set", 64'(overflow), 64'(1));
    check("ovf_count", 64'(count), 64'(16));
    clr_overflow = 1'b1; data_in = 64'hBEEF;
    step();
    check("ovf_set_wins", 64'(overflow), 64'(1));
    data_valid = 1'b0;
    step();
    clr_overflow = 1'b0;
    check("ovf_clear", 64'(overflow), 64'(0));

    // drain in order
    ack_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", 64'(head_valid), 64'(1));
      check("drain_data", head_data, 64'(i));
      step();
      reads++;
    end
    check("drain_count", 64'(count), 64'(0));
    check("drain_valid0", 64'(head_valid), 64'(0));

    // streaming against a queue model, ack toggling
    for (int n = 0; n < 64; n++) begin
      data_valid = 1'b1; data_in = 64'h1000 + 64'(n); ack_in = (n % 2 == 0);
      check("strm_ack", 64'(ack_out), 64'(mcnt < 16));
      check("strm_count", 64'(count), 64'(mcnt));
      check("strm_valid", 64'(head_valid), 64'(mcnt > 0));
      if (mcnt > 0) check("strm_data", head_data, q[0]);
      rd = (mcnt > 0) && ack_in;
      wr = (mcnt < 16);
      if (rd) begin void'(q.pop_front()); reads++; end
      if (wr) q.push_back(data_in); else mdrop = 1'b1;
      mcnt = mcnt + int'(wr) - int'(rd);
      step();
    end
    data_valid = 1'b0;
    check("strm_ovf", 64'(overflow), 64'(mdrop));
    ack_in = 1'b1;
    for (int k = 0; k < 20 && mcnt > 0; k++) begin
      check("strm_drain", head_data, q[0]);
      void'(q.pop_front());
      mcnt--;
      reads++;
      step();
    end
    check("strm_empty", 64'(count), 64'(0));
    check("strm_valid0", 64'(head_valid), 64'(0));
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("strm_ovf_clr", 64'(overflow), 64'(0));

    // asynchronous reset mid-operation
    ack_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_valid = 1'b1; data_in = 64'h2000 + 64'(i);
      step();
    end
    data_valid = 1'b0;
    check("mid_count7", 64'(count), 64'(7));
`ifdef STR_BUF_STATS_EN
    check("stats_reads", 64'(word_cnt), 64'(reads));
`endif
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_count", 64'(count), 64'(0));
    check("mid_rst_valid", 64'(head_valid), 64'(0));
    check("mid_rst_data", head_data, 64'(0));
`ifdef STR_BUF_STATS_EN
    check("stats_rst", 64'(word_cnt), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    data_valid = 1'b1; data_in = 64'hABC;
    step();
    data_valid = 1'b0; ack_in = 1'b1;
    check("post_rst_data", head_data, 64'hABC);
    check("post_rst_count", 64'(count), 64'(1));
    step();
    ack_in = 1'b0;
    check("post_rst_empty", 64'(count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
